// File: rtl/instruction_prefetch_queue.sv
// ---------------------------------------------------------------------------
// instruction_prefetch_queue
//
// DEPTH-entry instruction FIFO between instruction fetch and the control
// unit. The head entry is the current instruction and is decoded into the
// same fields as the single-entry instruction register. Fetch may run ahead
// of execution, and a branch discards prefetched words with flush.
//
// Optional feature macro: IPQ_PEEK_EN
//   Adds NEXT / NEXT_VALID, exposing the entry behind the head so the control
//   unit can pre-decode the following instruction.
//
// Ports
//   CLK                    clock, all state updates on the rising edge
//   RESET                  synchronous, active-low reset
//   in_valid / in          fetch offers an instruction word
//   in_ready               queue can accept a word (count < DEPTH)
//   advance                control unit consumes the head instruction
//   flush                  discard every queued instruction
//   out_valid / out        head entry present / head word (zero when empty)
//   OPCODE                 out[WIDTH-1 -: OPCODE_W]
//   REGISTER_ADRESS        out[WIDTH-OPCODE_W-1]
//   REGISTER_ADRESS_STACK  out[WIDTH-OPCODE_W-1 -: 2]
//   IMMEDIATE              out[WIDTH-OPCODE_W-2:0]
//   BA                     out[WIDTH-OPCODE_W-1:0]
//   count                  number of valid entries
//   NEXT / NEXT_VALID      second entry and its presence (IPQ_PEEK_EN only)
//
// Handshake: a word transfers on a rising edge exactly when in_valid and
// in_ready are both 1 (push); the head is consumed exactly when advance and
// out_valid are both 1 (pop). in_valid while full and advance while empty
// are ignored. in_ready and out_valid come from registered state only, so
// there is no combinational path from in_valid/advance to them.
// ---------------------------------------------------------------------------
module instruction_prefetch_queue #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 4,
  parameter int OPCODE_W = 6
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        in_valid,
  input  logic [WIDTH-1:0]            in,
  output logic                        in_ready,
  input  logic                        advance,
  input  logic                        flush,
  output logic                        out_valid,
  output logic [WIDTH-1:0]            out,
  output logic [OPCODE_W-1:0]         OPCODE,
  output logic                        REGISTER_ADRESS,
  output logic [1:0]                  REGISTER_ADRESS_STACK,
  output logic [WIDTH-OPCODE_W-2:0]   IMMEDIATE,
  output logic [WIDTH-OPCODE_W-1:0]   BA,
  output logic [$clog2(DEPTH+1)-1:0]  count
`ifdef IPQ_PEEK_EN
  ,
  output logic [WIDTH-1:0]            NEXT,
  output logic                        NEXT_VALID
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;

  logic push;
  logic pop;

  // Status flags come straight from the occupancy counter.
  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign count     = count_q;

  // Transfers are qualified by reset and flush so that a discarded push
  // never lands in storage and a discarded pop never moves a pointer.
  assign push = RESET && !flush && in_valid && in_ready;
  assign pop  = RESET && !flush && advance  && out_valid;

  // Storage is intentionally not reset or cleared on flush; the counter
  // alone decides which entries are meaningful.
  always_ff @(posedge CLK) begin
    if (push) begin
      storage[wr_ptr] <= in;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Head word is forced to zero when empty so every decoded field is zero too.
  always_comb begin
    out = '0;
    if (out_valid) begin
      out = storage[rd_ptr];
    end
  end

  assign OPCODE                = out[WIDTH-1 -: OPCODE_W];
  assign REGISTER_ADRESS       = out[WIDTH-OPCODE_W-1];
  assign REGISTER_ADRESS_STACK = out[WIDTH-OPCODE_W-1 -: 2];
  assign IMMEDIATE             = out[WIDTH-OPCODE_W-2:0];
  assign BA                    = out[WIDTH-OPCODE_W-1:0];

`ifdef IPQ_PEEK_EN
  assign NEXT_VALID = (count_q >= CW'(2));

  always_comb begin
    NEXT = '0;
    if (NEXT_VALID) begin
      NEXT = storage[rd_ptr + PW'(1)];
    end
  end
`endif

endmodule
